dut_pipe: RTL
=============

DUT_PIPE -- requirements
Module: dut_pipe

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- IN_W, 20, input vector width, ≥2.
- OUT_W, 40, output vector width, IN_W ≤ OUT_W ≤ 2*IN_W.
- DEPTH, 2, pipeline register stages, ≥1.
- SIG_W, 16, signature width, ≥2.
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL expose ports (name, direction, width, meaning):
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  input accepted this cycle when high with in_valid.
- in_data  in  IN_W  input vector.
- mode  in  2  function select, sampled with in_data.
- out_valid  out  1  output vector present.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  computed vector.
- sig_clear  in  1  clear signature and counter.
- sig  out  SIG_W  running MISR signature.
- vec_count  out  16  output handshakes since reset/clear.

Function
REQ-004 Input handshake SHALL be in_valid & in_ready; output handshake SHALL be out_valid & out_ready.
REQ-005 Stall SHALL equal out_valid & ~out_ready; in_ready SHALL equal ~stall (combinational).
REQ-006 When not stalled, every stage SHALL advance one position each cycle, carrying data, mode and a valid bit; stage 0 valid SHALL load the input handshake. When stalled, all stages SHALL hold.
REQ-007 Latency SHALL be exactly DEPTH cycles from input handshake to out_valid with no stall; throughput SHALL be one vector per cycle; bubbles SHALL NOT be collapsed.
REQ-008 For j = k mod IN_W, mode 00 (mapped) SHALL compute out[k] as follows:
- k < IN_W: in[k] ^ in[(k+1) mod IN_W].
- k ≥ IN_W: in[j] | in[(j+IN_W/2) mod IN_W].
REQ-009 Mode 01 (pass) SHALL set out[k] = in[k mod IN_W].
REQ-010 Mode 10 (inverted) SHALL output the bitwise complement of the mode-00 result.
REQ-011 Mode 11 (zero) SHALL output all zeros.
REQ-012 The function SHALL be evaluated in stage 0; later stages SHALL only delay.
REQ-013 fold(x) SHALL XOR the consecutive SIG_W-bit chunks of out_data, with the top chunk zero-padded.
REQ-014 On an output handshake, sig SHALL update to ((sig<<1) ^ (sig[SIG_W-1] ? POLY : 0)) ^ fold(out_data).
REQ-015 On an output handshake, vec_count SHALL increment, saturating at 16'hFFFF.
REQ-016 sig_clear without a handshake SHALL set sig=0 and vec_count=0.
REQ-017 sig_clear with a simultaneous handshake SHALL set sig=fold(out_data) and vec_count=1.
REQ-018 sig_clear SHALL NOT affect pipeline contents.
REQ-019 out_data SHALL be held stable while out_valid & ~out_ready.
REQ-020 Mode values SHALL travel with their vector; a mode change mid-stream SHALL NOT alter vectors already accepted.

Reset
REQ-021 rst SHALL take priority over all other inputs.
REQ-022 On rst, all stage valid bits SHALL clear, out_valid=0, out_data=0, sig=0 and vec_count=0.
REQ-023 in_ready SHALL be 1 in the first cycle after reset.
REQ-024 Reset mid-operation SHALL discard in-flight vectors without counting them or updating sig.

Verification (IN_W=20, OUT_W=40, DEPTH=2, SIG_W=16, POLY=16'h1021)
REQ-025 in_data=20'h00001, mode=00, out_ready=1 -> out_valid after 2 cycles, out_data=40'h0040180001.
REQ-026 Same in_data with mode=01 -> 40'h0000100001; with mode=10 -> 40'hFFBFE7FFFE; with mode=11 -> 0.
REQ-027 From reset, one mode-00 vector 20'h00001 handshaken -> sig=16'h4019, vec_count=1; sig_clear next cycle -> sig=0, vec_count=0.
REQ-028 Stream 4 vectors with out_ready=0 for 3 cycles after the first output -> in_ready=0 during stall, out_data held, all 4 outputs delivered in order, none lost or duplicated.
REQ-029 rst asserted with 2 vectors in flight -> next cycle out_valid=0, sig=0, vec_count=0; the discarded vectors never appear.
REQ-030 sig_clear coincident with an output handshake of 40'h0040180001 -> sig=16'h4019, vec_count=1.

Source files
------------

// File: rtl/dut_pipe.sv
// dut_pipe: mode-selected bit-mapping pipeline with stall backpressure and a MISR output signature
module dut_pipe #(
  parameter int IN_W = 20,
  parameter int OUT_W = 40,
  parameter int DEPTH = 2,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             sig_clear,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_count
);
  localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

  function automatic logic [OUT_W-1:0] fmap(input logic [IN_W-1:0] d, input logic [1:0] m);
    logic [OUT_W-1:0] mp, ps;
    mp = '0;
    ps = '0;
    for (int k = 0; k < OUT_W; k++) begin
      mp[k] = k < IN_W ? d[k] ^ d[(k + 1) % IN_W] : d[k % IN_W] | d[(k % IN_W + IN_W / 2) % IN_W];
      ps[k] = d[k % IN_W];
    end
    return m == 2'b00 ? mp : m == 2'b01 ? ps : m == 2'b10 ? ~mp : '0;
  endfunction

  function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] x);
    logic [NCH*SIG_W-1:0] p;
    logic [SIG_W-1:0] f;
    p = (NCH*SIG_W)'(x);
    f = '0;
    for (int c = 0; c < NCH; c++) f = f ^ p[c*SIG_W +: SIG_W];
    return f;
  endfunction

  logic [OUT_W-1:0] sd [DEPTH];
  logic [DEPTH-1:0] sv;
  logic stall, out_fire;

  assign out_valid = sv[DEPTH-1];
  assign out_data  = sd[DEPTH-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_fire  = out_valid & out_ready;

  // the mapping is applied on entry, so each vector carries the mode it was accepted with
  always_ff @(posedge clk) begin
    if (rst) begin
      sv <= '0;
      for (int i = 0; i < DEPTH; i++) sd[i] <= '0;
    end else if (!stall) begin
      sv[0] <= in_valid;
      sd[0] <= fmap(in_data, mode);
      for (int i = 1; i < DEPTH; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sd[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
      vec_count <= '0;
    end else if (sig_clear) begin
      sig <= out_fire ? fold(out_data) : '0;
      vec_count <= out_fire ? 16'd1 : 16'd0;
    end else if (out_fire) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold(out_data);
      vec_count <= vec_count == 16'hFFFF ? vec_count : vec_count + 16'd1;
    end
  end
endmodule
